pp_dio_sequencer: RTL and testbench

Parametrised digital-output sequencer for the pulse-programmer DIO path. It generalises the fixed 8-bit DO port into CH channels, fed from a DEPTH-entry event queue. Each event is an output word plus a hold time in clock cycles. After a start, the queue plays back gap-free with cycle-exact durations. It sits between the pulse-programmer core's DIO command output and the board DO pins.

---
 rtl/pp_dio_pkg.sv | 22 ++
 rtl/pp_dio_fifo.sv | 51 +++++
 rtl/pp_dio_sequencer.sv | 127 ++++++++++++
 tb/tb_pp_dio_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pp_dio_pkg.sv
// Shared types and sizing helpers for the DIO sequencer.
// PPDIO_MASK_EN widens each queue entry to carry a per-channel mask.
package pp_dio_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic int unsigned entry_w(input int unsigned ch, input int unsigned hold_w);
`ifdef PPDIO_MASK_EN
    return ch + hold_w + ch;
`else
    return ch + hold_w;
`endif
  endfunction

  function automatic int unsigned level_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pp_dio_fifo.sv
// Single-clock FIFO with synchronous clear and occupancy output.
// The head entry is read combinationally so a pop can load it at the same edge.
module pp_dio_fifo
  import pp_dio_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        push,
  input  logic [W-1:0]                din,
  input  logic                        pop,
  output logic [W-1:0]                dout,
  output logic [level_w(DEPTH)-1:0]   level
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  assign dout = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/pp_dio_sequencer.sv
// Queue-fed multi-channel digital-output sequencer with cycle-exact holds.
// Define PPDIO_MASK_EN to add the per-event channel write mask.
module pp_dio_sequencer
  import pp_dio_pkg::*;
#(
  parameter int unsigned   CH       = 8,
  parameter int unsigned   DEPTH    = 16,
  parameter int unsigned   HOLD_W   = 16,
  parameter logic [CH-1:0] IDLE_VAL = '0
) (
  input  logic                        wClk_i,
  input  logic                        wReset_i,
  input  logic                        wEvtValid_i,
  output logic                        wEvtReady_o,
  input  logic [CH-1:0]               wEvtValue_i,
`ifdef PPDIO_MASK_EN
  input  logic [CH-1:0]               wEvtMask_i,
`endif
  input  logic [HOLD_W-1:0]           wEvtHold_i,
  input  logic                        wStart_i,
  input  logic                        wAbort_i,
  output logic [CH-1:0]               rDO_o,
  output logic                        wBusy_o,
  output logic [level_w(DEPTH)-1:0]   wLevel_o,
  output logic                        rDone_o
);

  localparam int unsigned EW = entry_w(CH, HOLD_W);
  localparam int unsigned LW = level_w(DEPTH);

  state_t            state, state_next;
  logic [HOLD_W-1:0] cnt;
  logic [EW-1:0]     push_data;
  logic [EW-1:0]     head;
  logic              push;
  logic              load;
  logic              done_set;
  logic [HOLD_W-1:0] head_hold;
  logic [CH-1:0]     head_val;
  logic [CH-1:0]     do_next;

  assign wEvtReady_o = (wLevel_o < LW'(DEPTH)) && !wAbort_i;
  assign push        = wEvtValid_i && wEvtReady_o;
  assign wBusy_o     = (state == RUN);

`ifdef PPDIO_MASK_EN
  logic [CH-1:0] head_mask;
  assign push_data = {wEvtMask_i, wEvtValue_i, wEvtHold_i};
  assign head_mask = head[HOLD_W+CH +: CH];
  assign do_next   = (rDO_o & ~head_mask) | (head_val & head_mask);
`else
  assign push_data = {wEvtValue_i, wEvtHold_i};
  assign do_next   = head_val;
`endif

  assign head_hold = head[HOLD_W-1:0];
  assign head_val  = head[HOLD_W +: CH];

  pp_dio_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (wClk_i),
    .rst_n (wReset_i),
    .clear (wAbort_i),
    .push  (push),
    .din   (push_data),
    .pop   (load),
    .dout  (head),
    .level (wLevel_o)
  );

  always_ff @(posedge wClk_i or negedge wReset_i) begin
    if (!wReset_i) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    done_set   = 1'b0;
    if (wAbort_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (wStart_i && (wLevel_o != '0)) begin
            load       = 1'b1;
            state_next = RUN;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            if (wLevel_o != '0) begin
              load = 1'b1;
            end else begin
              state_next = IDLE;
              done_set   = 1'b1;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Hold 0 and 1 both load cnt=0, so every event lasts max(hold,1) cycles.
  always_ff @(posedge wClk_i or negedge wReset_i) begin
    if (!wReset_i) begin
      cnt     <= '0;
      rDO_o   <= IDLE_VAL;
      rDone_o <= 1'b0;
    end else begin
      rDone_o <= done_set;
      if (wAbort_i) begin
        cnt   <= '0;
        rDO_o <= IDLE_VAL;
      end else if (load) begin
        cnt   <= (head_hold == '0) ? '0 : head_hold - HOLD_W'(1);
        rDO_o <= do_next;
      end else if (state == RUN && cnt != '0) begin
        cnt <= cnt - HOLD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pp_dio_sequencer.sv
// Directed self-checking bench for pp_dio_sequencer (default 8ch / 16 deep).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_pp_dio_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        evt_valid;
  logic        evt_ready;
  logic [7:0]  evt_value;
  logic [7:0]  evt_mask;
  logic [15:0] evt_hold;
  logic        start;
  logic        abort;
  logic [7:0]  dout;
  logic        busy;
  logic [4:0]  level;
  logic        done;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  pp_dio_sequencer #(
    .CH       (8),
    .DEPTH    (16),
    .HOLD_W   (16),
    .IDLE_VAL (8'h00)
  ) dut (
    .wClk_i      (clk),
    .wReset_i    (rst_n),
    .wEvtValid_i (evt_valid),
    .wEvtReady_o (evt_ready),
    .wEvtValue_i (evt_value),
`ifdef PPDIO_MASK_EN
    .wEvtMask_i  (evt_mask),
`endif
    .wEvtHold_i  (evt_hold),
    .wStart_i    (start),
    .wAbort_i    (abort),
    .rDO_o       (dout),
    .wBusy_o     (busy),
    .wLevel_o    (level),
    .rDone_o     (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_evt(input logic [7:0] v, input logic [15:0] h, input logic [7:0] m);
    evt_valid = 1'b1;
    evt_value = v;
    evt_hold  = h;
    evt_mask  = m;
    tick();
    evt_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; evt_valid = 1'b0; evt_value = '0; evt_mask = '1;
    evt_hold = '0; start = 1'b0; abort = 1'b0;
    #12;
    chk("rst_do", dout, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_level", level, 0);
    chk("rst_ready", evt_ready, 1);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    tick();

    // basic playback, hold 0 behaves as 1
    push_evt(8'hA5, 16'd3, 8'hFF);
    push_evt(8'h0F, 16'd1, 8'hFF);
    push_evt(8'hFF, 16'd0, 8'hFF);
    chk("basic_level", level, 3);
    do_start();
    chk("basic_c1", dout, 8'hA5);
    chk("basic_busy", busy, 1);
    tick(); chk("basic_c2", dout, 8'hA5);
    tick(); chk("basic_c3", dout, 8'hA5);
    tick(); chk("basic_c4", dout, 8'h0F);
    tick(); chk("basic_c5", dout, 8'hFF); chk("basic_nodone", done, 0);
    tick(); chk("basic_done", done, 1); chk("basic_keep", dout, 8'hFF);
    chk("basic_idle", busy, 0);
    tick(); chk("basic_done_off", done, 0);

    // full queue
    for (int i = 0; i < 16; i++) push_evt(8'h10 + 8'(i), 16'd1, 8'hFF);
    chk("full_ready", evt_ready, 0);
    chk("full_level", level, 16);
    evt_valid = 1'b1; evt_value = 8'h77; evt_hold = 16'd1;
    tick(); chk("full_hold_level", level, 16);
    do_start();
    chk("full_e0", dout, 8'h10);
    chk("full_pop_level", level, 15);
    chk("full_ready_back", evt_ready, 1);
    tick();
    evt_valid = 1'b0;
    chk("full_e1", dout, 8'h11);
    chk("full_pushpop_level", level, 15);
    for (int i = 2; i < 16; i++) begin
      tick(); chk("full_seq", dout, 8'h10 + 8'(i));
    end
    tick(); chk("full_17th", dout, 8'h77); chk("full_17_busy", busy, 1);
    tick(); chk("full_done", done, 1);

    // abort with a simultaneous push
    tick();
    push_evt(8'h01, 16'd4, 8'hFF);
    push_evt(8'h02, 16'd4, 8'hFF);
    push_evt(8'h03, 16'd4, 8'hFF);
    push_evt(8'h04, 16'd4, 8'hFF);
    do_start();
    chk("abort_e1", dout, 8'h01);
    tick();
    abort = 1'b1; evt_valid = 1'b1; evt_value = 8'h55;
    #1 chk("abort_ready", evt_ready, 0);
    tick();
    abort = 1'b0; evt_valid = 1'b0;
    chk("abort_do", dout, 8'h00);
    chk("abort_level", level, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    tick(); chk("abort_done2", done, 0); chk("abort_level2", level, 0);

    // async reset mid-hold
    push_evt(8'h3C, 16'd10, 8'hFF);
    push_evt(8'h3D, 16'd10, 8'hFF);
    do_start();
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_do", dout, 8'h00);
    chk("arst_busy", busy, 0);
    chk("arst_level", level, 0);
    chk("arst_ready", evt_ready, 1);
    #3 rst_n = 1'b1;
    tick();
    do_start();
    chk("arst_empty_busy", busy, 0);
    chk("arst_empty_do", dout, 8'h00);
    tick(); chk("arst_empty_done", done, 0);

    // streaming: each event arrives before the previous hold expires
    push_evt(8'h21, 16'd3, 8'hFF);
    do_start();
    chk("strm_a1", dout, 8'h21);
    evt_valid = 1'b1; evt_value = 8'h22; evt_hold = 16'd2;
    tick(); evt_valid = 1'b0; chk("strm_a2", dout, 8'h21);
    tick(); chk("strm_a3", dout, 8'h21);
    evt_valid = 1'b1; evt_value = 8'h23; evt_hold = 16'd2;
    tick(); evt_valid = 1'b0; chk("strm_b1", dout, 8'h22);
    tick(); chk("strm_b2", dout, 8'h22); chk("strm_nodone", done, 0);
    tick(); chk("strm_c1", dout, 8'h23);
    tick(); chk("strm_c2", dout, 8'h23); chk("strm_busy", busy, 1);
    tick(); chk("strm_done", done, 1); chk("strm_idle", busy, 0);
    tick(); chk("strm_done_once", done, 0);

    // masked load versus plain load
    push_evt(8'hF0, 16'd1, 8'hFF);
    push_evt(8'h0F, 16'd2, 8'h03);
    do_start();
    chk("mask_pre", dout, 8'hF0);
`ifdef PPDIO_MASK_EN
    tick(); chk("mask_c1", dout, 8'hF3);
    tick(); chk("mask_c2", dout, 8'hF3);
`else
    tick(); chk("mask_c1", dout, 8'h0F);
    tick(); chk("mask_c2", dout, 8'h0F);
`endif
    tick(); chk("mask_done", done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
